ccc_lock_seq: RTL and testbench

Lock monitor and reset sequencer for the fabric CCC. Runs on the free-running on-chip RC oscillator, never on GL0. Synchronizes and filters the CCC LOCK output, holds the fabric reset until the PLL has been stable for a programmable time, and re-kicks the PLL through PLL_ARST_N when lock is not reached in time. Sits between the CCC instance and the fabric reset tree, and reports lock-loss and retry statistics to the system controller.

---
 rtl/ccc_lock_seq_if.sv | 22 ++
 rtl/ccc_lock_seq.sv | 112 +++++++++++
 tb/tb_ccc_lock_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ccc_lock_seq_if.sv
// Signal bundle between the CCC lock sequencer and its environment.
// The slave modport is the sequencer side; master drives LOCK and the software request.
interface ccc_lock_seq_if;
  logic       lock_i;
  logic       sw_reset_req_i;
  logic       fab_resetn_o;
  logic       ready_o;
  logic       pll_arst_n_o;
  logic [7:0] lost_cnt_o;
  logic [3:0] retry_cnt_o;
  logic [1:0] state_o;

  modport slave (
    input  lock_i, sw_reset_req_i,
    output fab_resetn_o, ready_o, pll_arst_n_o, lost_cnt_o, retry_cnt_o, state_o
  );

  modport master (
    output lock_i, sw_reset_req_i,
    input  fab_resetn_o, ready_o, pll_arst_n_o, lost_cnt_o, retry_cnt_o, state_o
  );
endinterface

// File: rtl/ccc_lock_seq.sv
// CCC lock monitor and fabric reset sequencer on the RC oscillator clock.
// Filters a synchronized LOCK, holds fabric reset, and re-kicks the PLL on relock timeout.
module ccc_lock_seq #(
  parameter int unsigned LOCK_FILTER    = 4,
  parameter int unsigned RESET_HOLD     = 8,
  parameter int unsigned RELOCK_TIMEOUT = 100,
  parameter int unsigned PLL_RST_PULSE  = 10
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  ccc_lock_seq_if.slave  bus
);

  localparam logic [15:0] FILTER_LAST  = 16'(LOCK_FILTER - 1);
  localparam logic [15:0] HOLD_LAST    = 16'(RESET_HOLD - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(RELOCK_TIMEOUT - 1);
  localparam logic [15:0] PULSE_LAST   = 16'(PLL_RST_PULSE - 1);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_FILTER,
    ST_HOLD,
    ST_RUN,
    ST_PLL_RST
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q;
  logic        sync1_q, lock_s_q;
  logic        fab_resetn_q, ready_q, pll_arst_n_q;
  logic [7:0]  lost_cnt_q;
  logic [3:0]  retry_cnt_q;
  logic        lost_evt, retry_evt;

  always_comb begin
    state_d   = state_q;
    lost_evt  = 1'b0;
    retry_evt = 1'b0;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = ST_FILTER;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = ST_PLL_RST;
          retry_evt = 1'b1;
        end
      end
      // LOCK is meaningless while the PLL is held in reset.
      ST_PLL_RST: begin
        if (cnt_q == PULSE_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_FILTER: begin
        if (!lock_s_q)                 state_d = ST_WAIT_LOCK;
        else if (cnt_q == FILTER_LAST) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!lock_s_q)               state_d = ST_WAIT_LOCK;
        else if (cnt_q == HOLD_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Lock loss takes priority over a software reset request.
        if (!lock_s_q) begin
          state_d  = ST_WAIT_LOCK;
          lost_evt = 1'b1;
        end else if (bus.sw_reset_req_i) begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q      <= 1'b0;
      lock_s_q     <= 1'b0;
      state_q      <= ST_WAIT_LOCK;
      cnt_q        <= 16'd0;
      fab_resetn_q <= 1'b0;
      ready_q      <= 1'b0;
      pll_arst_n_q <= 1'b1;
      lost_cnt_q   <= 8'd0;
      retry_cnt_q  <= 4'd0;
    end else begin
      sync1_q      <= bus.lock_i;
      lock_s_q     <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
      fab_resetn_q <= (state_d == ST_RUN);
      ready_q      <= (state_d == ST_RUN);
      pll_arst_n_q <= (state_d != ST_PLL_RST);
      if (lost_evt && (lost_cnt_q != 8'hFF))  lost_cnt_q  <= lost_cnt_q + 8'd1;
      if (retry_evt && (retry_cnt_q != 4'hF)) retry_cnt_q <= retry_cnt_q + 4'd1;
    end
  end

  always_comb begin
    case (state_q)
      ST_FILTER: bus.state_o = 2'd1;
      ST_HOLD:   bus.state_o = 2'd2;
      ST_RUN:    bus.state_o = 2'd3;
      default:   bus.state_o = 2'd0;
    endcase
  end

  assign bus.fab_resetn_o = fab_resetn_q;
  assign bus.ready_o      = ready_q;
  assign bus.pll_arst_n_o = pll_arst_n_q;
  assign bus.lost_cnt_o   = lost_cnt_q;
  assign bus.retry_cnt_o  = retry_cnt_q;

endmodule

// File: tb/tb_ccc_lock_seq.sv
// Randomized bench for ccc_lock_seq with a timeline-based reference model and a queue scoreboard.
module tb_ccc_lock_seq;
  localparam int LF = 4;
  localparam int RH = 8;
  localparam int RT = 100;
  localparam int PP = 10;

  localparam int P_WAIT   = 0;
  localparam int P_FILTER = 1;
  localparam int P_HOLD   = 2;
  localparam int P_RUN    = 3;
  localparam int P_PLL    = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ccc_lock_seq_if bus ();

  ccc_lock_seq #(
    .LOCK_FILTER(LF), .RESET_HOLD(RH), .RELOCK_TIMEOUT(RT), .PLL_RST_PULSE(PP)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       fab;
    logic       rdy;
    logic       pll;
    logic [7:0] lost;
    logic [3:0] retry;
    logic [1:0] st;
  } obs_t;

  obs_t exp_q[$];
  int   edge_q[$];
  event chk_ev;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: current phase, the edge it began on, and LOCK as seen two samples late.
  int   k = 0;
  int   m_phase, m_entered, m_lost, m_retry;
  logic m_h0, m_h1;

  function automatic obs_t model_out();
    obs_t o;
    o.fab   = (m_phase == P_RUN);
    o.rdy   = (m_phase == P_RUN);
    o.pll   = (m_phase != P_PLL);
    o.lost  = 8'(m_lost);
    o.retry = 4'(m_retry);
    o.st    = (m_phase == P_PLL) ? 2'd0 : 2'(m_phase);
    return o;
  endfunction

  task automatic model_reset();
    m_phase = P_WAIT; m_entered = k; m_lost = 0; m_retry = 0; m_h0 = 1'b0; m_h1 = 1'b0;
  endtask

  task automatic go(input int ph);
    m_phase = ph; m_entered = k;
  endtask

  task automatic model_step(input logic lk, input logic sw);
    logic ls;
    int   el;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ls = m_h1; m_h1 = m_h0; m_h0 = lk;
    el = k - m_entered;
    case (m_phase)
      P_WAIT:   if (ls) go(P_FILTER);
                else if (el == RT) begin go(P_PLL); if (m_retry < 15) m_retry++; end
      P_PLL:    if (el == PP) go(P_WAIT);
      P_FILTER: if (!ls) go(P_WAIT); else if (el == LF) go(P_HOLD);
      P_HOLD:   if (!ls) go(P_WAIT); else if (el == RH) go(P_RUN);
      default:  if (!ls) begin go(P_WAIT); if (m_lost < 255) m_lost++; end
                else if (sw) go(P_HOLD);
    endcase
  endtask

  task automatic cyc(input logic lk, input logic sw);
    bus.lock_i = lk;
    bus.sw_reset_req_i = sw;
    @(posedge clk);
    k++;
    model_step(lk, sw);
    exp_q.push_back(model_out());
    edge_q.push_back(k);
    #1;
  endtask

  task automatic run(input int n, input logic lk, input logic sw);
    for (int i = 0; i < n; i++) cyc(lk, sw);
  endtask

  // Asynchronous reset in mid-operation; outputs are checked right after assertion.
  task automatic hit_reset(input int n);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    exp_q.push_back(model_out());
    edge_q.push_back(k);
    ->chk_ev;
    run(n, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    obs_t e, a;
    int   ek;
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ek = edge_q.pop_front();
        a  = {bus.fab_resetn_o, bus.ready_o, bus.pll_arst_n_o,
              bus.lost_cnt_o, bus.retry_cnt_o, bus.state_o};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs edge %0d: got fab=%b rdy=%b pll=%b lost=%0d retry=%0d st=%0d, want fab=%b rdy=%b pll=%b lost=%0d retry=%0d st=%0d",
                   ek, a.fab, a.rdy, a.pll, a.lost, a.retry, a.st,
                   e.fab, e.rdy, e.pll, e.lost, e.retry, e.st);
        end
      end
    end
  end

  initial begin : stim
    logic lk;
    int   len;
    rst_n = 1'b0;
    bus.lock_i = 1'b0;
    bus.sw_reset_req_i = 1'b0;
    model_reset();
    run(3, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Clean lock-up from reset.
    run(30, 1'b1, 1'b0);
    // Single-cycle software reset request in RUN.
    cyc(1'b1, 1'b1);
    run(20, 1'b1, 1'b0);
    // Five-cycle lock drop and recovery.
    run(5, 1'b0, 1'b0);
    run(30, 1'b1, 1'b0);
    // Drops during FILTER and during HOLD.
    run(5, 1'b0, 1'b0);
    run(4, 1'b1, 1'b0);
    run(2, 1'b0, 1'b0);
    run(9, 1'b1, 1'b0);
    run(2, 1'b0, 1'b0);
    run(30, 1'b1, 1'b0);
    // Software request lands on the same edge the lock loss is seen.
    run(2, 1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    run(30, 1'b1, 1'b0);

    // Lock held low long enough for the retry counter to saturate.
    hit_reset(2);
    run(1800, 1'b0, 1'b0);
    run(30, 1'b1, 1'b0);

    // Randomized lock runs with sporadic software requests.
    for (int s = 0; s < 120; s++) begin
      lk = 1'($urandom_range(0, 1));
      if (lk) len = $urandom_range(1, 40);
      else if ($urandom_range(0, 3) == 0) len = $urandom_range(90, 130);
      else len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) cyc(lk, ($urandom_range(0, 9) == 0));
    end

    // Reset asserted during a PLL_ARST_N pulse.
    run(30, 1'b1, 1'b0);
    run(105, 1'b0, 1'b0);
    hit_reset(3);

    // Drive LOST_CNT into saturation, then reset.
    run(30, 1'b1, 1'b0);
    for (int i = 0; i < 260; i++) begin
      cyc(1'b0, 1'b0);
      run(25, 1'b1, 1'b0);
    end
    run(10, 1'b1, 1'b0);
    hit_reset(3);
    run(20, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
